// File: rtl/mpmp_fifo_pkg.sv
// Shared helpers for the multi-push/multi-pop flow-controlled FIFO.
// Pointer math uses compare-and-subtract so any depth works, not just powers of two.
package mpmp_fifo_pkg;

    function automatic int unsigned sat_min(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

    // Caller guarantees ptr < depth and inc <= depth, so one subtraction suffices.
    function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned inc,
                                             input int unsigned depth);
        int unsigned s;
        s = ptr + inc;
        return (s >= depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/mpmp_fifo_ctrl.sv
// Pointer, level and error-flag bookkeeping for mpmp_fifo_flow.
// All status outputs depend only on registered state.
module mpmp_fifo_ctrl
    import mpmp_fifo_pkg::*;
#(
    parameter int unsigned D        = 8,
    parameter int unsigned N        = 4,
    parameter int unsigned AF_LEVEL = D - N,
    parameter int unsigned AE_LEVEL = N - 1,
    parameter int unsigned WN       = $clog2(N + 1),
    parameter int unsigned WL       = $clog2(D + 1),
    parameter int unsigned WP       = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          arstn,
    input  logic          flush,
    input  logic          clear_err,
    input  logic [WN-1:0] push,
    input  logic [WN-1:0] pop,
    output logic          wr_en,
    output logic [WP-1:0] wr_ptr,
    output logic [WP-1:0] rd_ptr,
    output logic [WN-1:0] can_push,
    output logic [WN-1:0] can_pop,
    output logic [WL-1:0] level,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          overflow,
    output logic          underflow
);

    logic [WP-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WL-1:0] level_q, level_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          push_ok, pop_ok;
    int unsigned   lvl, cp, cpop, push_v, pop_v;

    always_comb begin
        lvl    = 32'(level_q);
        cp     = sat_min(N, D - lvl);
        cpop   = sat_min(N, lvl);
        push_ok = 32'(push) <= cp;
        pop_ok  = 32'(pop) <= cpop;
        push_v = push_ok ? 32'(push) : 0;
        pop_v  = pop_ok ? 32'(pop) : 0;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q & ~clear_err;
        unf_d    = unf_q & ~clear_err;
        wr_en    = 1'b0;

        if (flush) begin
            // Flush discards any concurrent request without flagging it.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = WP'(wrap_add(32'(wr_ptr_q), push_v, D));
                wr_en    = (push != '0);
            end else begin
                ovf_d = 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = WP'(wrap_add(32'(rd_ptr_q), pop_v, D));
            end else begin
                unf_d = 1'b1;
            end
            level_d = WL'(lvl + push_v - pop_v);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign wr_ptr       = wr_ptr_q;
    assign rd_ptr       = rd_ptr_q;
    assign level        = level_q;
    assign can_push     = WN'(cp);
    assign can_pop      = WN'(cpop);
    assign almost_full  = lvl >= AF_LEVEL;
    assign almost_empty = lvl <= AE_LEVEL;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: rtl/mpmp_fifo_flow.sv
// Multi-push/multi-pop FIFO with first-word-fall-through pop lanes, level,
// almost thresholds, flush and sticky error flags. Storage and lane muxing live here.
module mpmp_fifo_flow
    import mpmp_fifo_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned D        = 8,
    parameter int unsigned N        = 4,
    parameter int unsigned AF_LEVEL = D - N,
    parameter int unsigned AE_LEVEL = N - 1,
    localparam int unsigned WN      = $clog2(N + 1),
    localparam int unsigned WL      = $clog2(D + 1)
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                flush,
    input  logic [WN-1:0]       push,
    input  logic [N-1:0][W-1:0] push_data,
    input  logic [WN-1:0]       pop,
    output logic [N-1:0][W-1:0] pop_data,
    output logic [WN-1:0]       can_push,
    output logic [WN-1:0]       can_pop,
    output logic [WL-1:0]       level,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow,
    input  logic                clear_err
);

    localparam int unsigned WP = (D > 1) ? $clog2(D) : 1;

    logic [W-1:0]  mem [D];
    logic          wr_en;
    logic [WP-1:0] wr_ptr, rd_ptr;

    mpmp_fifo_ctrl #(
        .D        (D),
        .N        (N),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL),
        .WN       (WN),
        .WL       (WL),
        .WP       (WP)
    ) u_ctrl (
        .clk          (clk),
        .arstn        (arstn),
        .flush        (flush),
        .clear_err    (clear_err),
        .push         (push),
        .pop          (pop),
        .wr_en        (wr_en),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .can_push     (can_push),
        .can_pop      (can_pop),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (i < 32'(push)) begin
                    mem[WP'(wrap_add(32'(wr_ptr), i, D))] <= push_data[i];
                end
            end
        end
    end

    // Lanes beyond the stored count read as zero so stale memory never leaks out.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            pop_data[i] = '0;
            if (i < 32'(can_pop)) begin
                pop_data[i] = mem[WP'(wrap_add(32'(rd_ptr), i, D))];
            end
        end
    end

endmodule

// File: tb/tb_mpmp_fifo_flow.sv
// Directed bench for mpmp_fifo_flow with a queue scoreboard; D=8 and D=6 instances
// share stimulus and one of them is observed per phase.
module tb_mpmp_fifo_flow;

    logic             clk = 1'b0;
    logic             arstn;
    logic             flush;
    logic             clear_err;
    logic [2:0]       push, pop;
    logic [3:0][7:0]  push_data;

    logic [3:0][7:0]  pd8, pd6;
    logic [2:0]       cpu8, cpo8, cpu6, cpo6;
    logic [3:0]       lvl8;
    logic [2:0]       lvl6;
    logic             af8, ae8, ov8, un8, af6, ae6, ov6, un6;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    bit         m_ovf, m_unf;
    bit         sel6;

    always #5 clk = ~clk;

    mpmp_fifo_flow #(.W(8), .D(8), .N(4)) dut8 (
        .clk(clk), .arstn(arstn), .flush(flush), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pd8), .can_push(cpu8), .can_pop(cpo8), .level(lvl8),
        .almost_full(af8), .almost_empty(ae8), .overflow(ov8), .underflow(un8),
        .clear_err(clear_err)
    );

    mpmp_fifo_flow #(.W(8), .D(6), .N(4)) dut6 (
        .clk(clk), .arstn(arstn), .flush(flush), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(pd6), .can_push(cpu6), .can_pop(cpo6), .level(lvl6),
        .almost_full(af6), .almost_empty(ae6), .overflow(ov6), .underflow(un6),
        .clear_err(clear_err)
    );

    function automatic logic [3:0][7:0] w4(input int a, input int b, input int c, input int d);
        logic [3:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        return r;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every observable output of the selected instance against the model.
    task automatic check_all(input string tag);
        int sz = m_q.size();
        int d  = sel6 ? 6 : 8;
        logic [3:0][7:0] pd;
        pd = sel6 ? pd6 : pd8;
        chk({tag, ".level"},    sel6 ? 32'(lvl6) : 32'(lvl8), 32'(sz));
        chk({tag, ".can_push"}, sel6 ? 32'(cpu6) : 32'(cpu8), 32'(min2(4, d - sz)));
        chk({tag, ".can_pop"},  sel6 ? 32'(cpo6) : 32'(cpo8), 32'(min2(4, sz)));
        chk({tag, ".af"},       32'(sel6 ? af6 : af8), 32'(sz >= d - 4));
        chk({tag, ".ae"},       32'(sel6 ? ae6 : ae8), 32'(sz <= 3));
        chk({tag, ".ovf"},      32'(sel6 ? ov6 : ov8), 32'(m_ovf));
        chk({tag, ".unf"},      32'(sel6 ? un6 : un8), 32'(m_unf));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.lane%0d", tag, i), 32'(pd[i]), (i < sz) ? 32'(m_q[i]) : 32'd0);
        end
    endtask

    // Drive one cycle of stimulus (called just after a falling edge); model uses pre-edge state.
    task automatic step(input int pn, input logic [3:0][7:0] d, input int popn,
                        input bit fl, input bit clr);
        int sz = m_q.size();
        int dd = sel6 ? 6 : 8;
        bit newo, newu;
        push = 3'(pn); push_data = d; pop = 3'(popn); flush = fl; clear_err = clr;
        if (fl) begin
            m_q.delete();
            m_ovf = m_ovf && !clr;
            m_unf = m_unf && !clr;
        end else begin
            newo = pn > min2(4, dd - sz);
            newu = popn > min2(4, sz);
            if (!newu) repeat (popn) void'(m_q.pop_front());
            if (!newo) for (int i = 0; i < pn; i++) m_q.push_back(d[i]);
            m_ovf = (m_ovf && !clr) || newo;
            m_unf = (m_unf && !clr) || newu;
        end
        @(posedge clk);
        #1;
        push = '0; pop = '0; flush = 1'b0; clear_err = 1'b0; push_data = '0;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit use6);
        arstn = 1'b0;
        sel6  = use6;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        arstn = 1'b0; flush = 1'b0; clear_err = 1'b0;
        push = '0; pop = '0; push_data = '0;
        sel6 = 1'b0;
        @(negedge clk);
        check_all("reset");
        do_reset(1'b0);

        // Asynchronous reset mid-cycle with level 5
        step(4, w4(11, 12, 13, 14), 0, 0, 0);
        step(1, w4(15, 0, 0, 0), 0, 0, 0);
        chk("pre_rst.level", 32'(lvl8), 32'd5);
        @(posedge clk);
        #2;
        arstn = 1'b0;
        m_q.delete();
        #1;
        chk("async_rst.level", 32'(lvl8), 32'd0);
        chk("async_rst.can_push", 32'(cpu8), 32'd4);
        chk("async_rst.pop_data", 32'(pd8), 32'd0);
        check_all("async_rst");
        do_reset(1'b0);

        // Push three then pop one at a time
        step(3, w4(1, 2, 3, 0), 0, 0, 0);
        check_all("p2.fill");
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("p2.head%0d", k), 32'(pd8[0]), 32'(k));
            step(0, '0, 1, 0, 0);
            check_all($sformatf("p2.pop%0d", k));
        end

        // Fill to full then overflow
        step(4, w4(1, 2, 3, 4), 0, 0, 0);
        step(4, w4(5, 6, 7, 8), 0, 0, 0);
        chk("p3.full_level", 32'(lvl8), 32'd8);
        chk("p3.almost_full", 32'(af8), 32'd1);
        check_all("p3.full");
        step(1, w4(99, 0, 0, 0), 0, 0, 0);
        chk("p3.overflow", 32'(ov8), 32'd1);
        check_all("p3.ovf");
        step(0, '0, 0, 0, 1);
        check_all("p3.clr");

        // Wrap-around on the non-power-of-two instance
        do_reset(1'b1);
        step(4, w4(1, 2, 3, 4), 0, 0, 0);
        step(2, w4(5, 6, 0, 0), 0, 0, 0);
        check_all("p4.fill");
        step(0, '0, 4, 0, 0);
        step(4, w4(7, 8, 9, 10), 0, 0, 0);
        chk("p4.wrap_data", 32'(pd6), 32'(w4(5, 6, 7, 8)));
        check_all("p4.wrap");
        step(0, '0, 4, 0, 0);
        chk("p4.tail_data", 32'(pd6), 32'(w4(9, 10, 0, 0)));
        check_all("p4.tail");

        // Simultaneous push/pop, then underflow and set-wins-over-clear
        do_reset(1'b0);
        step(2, w4(8'hA, 8'hB, 0, 0), 0, 0, 0);
        step(3, w4(8'hC, 8'hD, 8'hE, 0), 2, 0, 0);
        chk("p5.data", 32'(pd8), 32'(w4(8'hC, 8'hD, 8'hE, 0)));
        check_all("p5.both");
        step(0, '0, 4, 0, 0);
        chk("p5.underflow", 32'(un8), 32'd1);
        check_all("p5.unf");
        step(0, '0, 4, 0, 1);
        check_all("p5.set_wins");
        step(0, '0, 0, 0, 1);
        check_all("p5.clr");

        // Flush beats push, flags untouched, then out-of-range push count
        do_reset(1'b0);
        step(4, w4(1, 2, 3, 4), 0, 0, 0);
        step(3, w4(5, 6, 7, 0), 0, 0, 0);
        check_all("p6.level7");
        step(2, w4(20, 21, 0, 0), 0, 1, 0);
        chk("p6.flush_ovf", 32'(ov8), 32'd0);
        check_all("p6.flush");
        step(1, w4(9, 0, 0, 0), 0, 0, 0);
        chk("p6.after", 32'(pd8[0]), 32'd9);
        check_all("p6.after");
        step(7, w4(1, 2, 3, 4), 0, 0, 0);
        check_all("p6.push7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpmp_fifo_flow.md
Name: mpmp_fifo_flow

Overview:
Parametrised successor to the multi-push/multi-pop FIFO: accepts 0..N words and releases 0..N words per cycle.
- Pop data is first-word-fall-through.
- Adds occupancy level, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Supports depths that are not powers of two.
- Sits between the UART byte path and the FFT sample packer, absorbing bursty multi-word transfers.

Parameters:
W, 8, data word width in bits
D, 8, depth in words; legal range D >= N, any integer (not restricted to a power of two)
N, 4, maximum words pushed or popped per cycle
AF_LEVEL, D-N, almost_full asserts when level >= AF_LEVEL
AE_LEVEL, N-1, almost_empty asserts when level <= AE_LEVEL
WN, $clog2(N+1), width of count ports (derived, not overridable)
WL, $clog2(D+1), width of level (derived)

Ports:
clk  in  1  single clock, rising edge
arstn  in  1  asynchronous reset, active-low
flush  in  1  synchronous clear of contents
push  in  WN  number of words to write this cycle (0..N)
push_data  in  [N-1:0][W-1:0]  lane 0 is the oldest word and is written first
pop  in  WN  number of words to remove this cycle (0..N)
pop_data  out  [N-1:0][W-1:0]  lane i = i-th oldest stored word
can_push  out  WN  min(N, D-level)
can_pop  out  WN  min(N, level)
level  out  WL  words currently stored
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level <= AE_LEVEL
overflow  out  1  sticky: illegal push seen
underflow  out  1  sticky: illegal pop seen
clear_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- State: wr_ptr, rd_ptr (0..D-1), level (0..D), error flags, storage array D x W. Storage is not reset.
- Reset (arstn low, asynchronous, at any time including mid-transfer):
  - wr_ptr = rd_ptr = level = 0; flags = 0.
  - Outputs immediately become: can_push = N, can_pop = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0), pop_data = all zeros.
- All outputs are combinational from registered state only. No combinational path from push/pop to can_push/can_pop/level.
- Push legality: push <= can_push (pre-edge value).
  - Legal: lanes 0..push-1 are written to mem[(wr_ptr+i) mod D], and wr_ptr advances by push mod D.
  - Illegal: the entire request is dropped (no partial write), state is unchanged, overflow is set.
- Pop legality: pop <= can_pop (pre-edge value).
  - Legal: rd_ptr advances by pop mod D.
  - Illegal: the request is dropped and underflow is set.
- Simultaneous push and pop: each is checked independently against pre-edge level. No pass-through: a word pushed in cycle t is first visible in pop_data in cycle t+1. Next level = level + legal push - legal pop.
- Latency: push-to-visible is 1 cycle; pop takes effect at the next edge.
- Data visibility: pop_data[i] = mem[(rd_ptr+i) mod D] for i < can_pop; lanes i >= can_pop read as 0.
- Wrap-around: pointer addition uses a compare-and-subtract against D (sum < 2D always), never a bit truncation. Required for D not a power of two.
- flush: has priority over push and pop. Next pointers = 0 and level = 0. Flags are untouched. A push in the flush cycle is discarded without setting overflow.
- Error flags:
  - clear_err clears both flags.
  - If a new error occurs in the same cycle as clear_err, the flag reads 1 (set wins).
- push = 0 or pop = 0: no state change.
- Values above N are illegal by definition. They set the corresponding error flag, since can_push/can_pop never exceed N.

Decomposition:
- Package mpmp_fifo_pkg holds the function sat_min(a, b) and the function wrap_add(ptr, inc, D) used for pointer arithmetic.
- Width parameters stay as module parameters, since they are per instance.
- One sub-module, mpmp_fifo_ctrl: pointers, level, legality, flags, can_push/can_pop.
- The top module holds storage plus the write and read lane muxing.

Test Plan:
1. Reset: drive arstn low mid-cycle with level 5 -> immediately level = 0, can_push = 4, can_pop = 0, almost_empty = 1, pop_data = 0.
2. Push 3 words {1,2,3}, then pop 1 on each of three cycles -> pop_data[0] reads 1, 2, 3 in turn; level goes 3, 2, 1, 0; can_pop reads 3, 2, 1, 0.
3. Push 4 {1,2,3,4}, then push 4 {5,6,7,8} -> level = 8, can_push = 0, almost_full = 1. Then push 1 -> overflow = 1, level stays 8, data unchanged. Then clear_err -> overflow = 0.
4. Wrap with D = 6: fill with {1..6}, pop 4, push 4 {7,8,9,10} -> pop_data = {5,6,7,8}; after pop 4 -> {9,10,0,0}, can_pop = 2.
5. With level 2 holding {a,b}: push 3 {c,d,e} and pop 2 in the same cycle -> level = 3, pop_data = {c,d,e,0}. Then pop 4 with level 3 -> underflow = 1, level stays 3.
6. flush with push 2 in the same cycle, level 7 -> level = 0, overflow stays 0, can_push = 4. Next push 1 {9} -> pop_data[0] = 9.
